sampling_index_gen: RTL

//  Sits directly downstream of the synchronizer. Consumes the free-running 64-bit SYS_TIME
//  (20.48 MHz ticks, may stall or skip one tick) and produces the sample index
//  IDX = floor(SYS_TIME / FREQ_DIV) mod CYCLE for the modulation/STM stages.
//  IDX is bit-identical on every device sharing the same SYS_TIME.

---
 rtl/sampling_index_gen.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sampling_index_gen.sv
// sampling_index_gen
//   Derives the sample index IDX = floor(SYS_TIME / FREQ_DIV) mod CYCLE from the
//   free-running 64-bit system time. An exact bit-serial divide runs once per
//   (re)lock against a future target time T0. After that the index is tracked
//   incrementally with a phase accumulator, so every device that sees the same
//   SYS_TIME produces the same IDX.
//
// Ports
//   CLK         system clock
//   RST         synchronous reset, active-high
//   SYS_TIME    64-bit system time from the synchronizer (+0/+1/+2 per cycle)
//   FREQ_DIV    ticks per sample, latched on UPDATE (values below 2 become 2)
//   CYCLE       samples per cycle, latched on UPDATE (0 becomes 1)
//   UPDATE      1-cycle pulse: latch FREQ_DIV/CYCLE and force a resync
//   IDX         current sample index
//   IDX_UPDATE  1-cycle pulse whenever IDX is (re)written
//   LOCKED      high while IDX tracks SYS_TIME
//   RESYNC_CNT  (only with SAMPLING_INDEX_GEN_RESYNC_CNT_EN) saturating count
//               of entries into CAPTURE, excluding the entry from reset
//
// Build option: define SAMPLING_INDEX_GEN_RESYNC_CNT_EN to add RESYNC_CNT.

module sampling_index_gen #(
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned RESYNC_LEAD = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [63:0]      SYS_TIME,
  input  logic [DIV_W-1:0] FREQ_DIV,
  input  logic [IDX_W-1:0] CYCLE,
  input  logic             UPDATE,
  output logic [IDX_W-1:0] IDX,
  output logic             IDX_UPDATE,
  output logic             LOCKED
`ifdef SAMPLING_INDEX_GEN_RESYNC_CNT_EN
  ,
  output logic [15:0]      RESYNC_CNT
`endif
);

  typedef enum logic [2:0] {
    ST_CAPTURE,
    ST_DIV_T,
    ST_DIV_Q,
    ST_WAIT,
    ST_TRACK
  } state_t;

  state_t           state, state_nxt;
  logic [63:0]      prev_time;
  logic [63:0]      t0, t0_nxt;
  logic [63:0]      quo, quo_nxt;
  logic [DIV_W-1:0] rem_t, rem_t_nxt;
  logic [IDX_W-1:0] rem_q, rem_q_nxt;
  logic [5:0]       cnt, cnt_nxt;
  logic [DIV_W-1:0] div_r, div_nxt;
  logic [IDX_W-1:0] cyc_r, cyc_nxt;
  logic [IDX_W-1:0] i0, i0_nxt;
  logic [DIV_W:0]   phase, phase_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             idx_upd_nxt;
  logic             locked_nxt;

  // Free-running time difference; a backward jump shows up as a huge value.
  logic [63:0]      delta;
  assign delta = SYS_TIME - prev_time;

  // One restoring-divide step of T0 / FREQ_DIV (quotient shifts through quo).
  logic [DIV_W:0]   t_trial;
  logic             t_ge;
  logic [DIV_W-1:0] t_sub;
  assign t_trial = {rem_t, quo[63]};
  assign t_ge    = t_trial >= {1'b0, div_r};
  assign t_sub   = DIV_W'(t_trial - {1'b0, div_r});

  // One restoring-remainder step of q mod CYCLE (q shifts out of quo).
  logic [IDX_W:0]   q_trial;
  logic             q_ge;
  logic [IDX_W-1:0] q_sub;
  logic [IDX_W-1:0] rem_q_step;
  assign q_trial    = {rem_q, quo[63]};
  assign q_ge       = q_trial >= {1'b0, cyc_r};
  assign q_sub      = IDX_W'(q_trial - {1'b0, cyc_r});
  assign rem_q_step = q_ge ? q_sub : q_trial[IDX_W-1:0];

  // Lock-time alignment: SYS_TIME may land on T0 or one tick past it.
  logic [63:0]      e;
  logic [DIV_W:0]   w_phase_raw;
  logic             w_wrap;
  logic [IDX_W-1:0] i0_inc;
  assign e           = SYS_TIME - t0;
  assign w_phase_raw = {1'b0, rem_t} + {{DIV_W{1'b0}}, e[0]};
  assign w_wrap      = w_phase_raw >= {1'b0, div_r};
  assign i0_inc      = (i0 == cyc_r - IDX_W'(1)) ? '0 : i0 + IDX_W'(1);

  // Tracking: with FREQ_DIV >= 2 and delta <= 2 at most one wrap can occur.
  logic [DIV_W:0]   tr_phase_raw;
  logic             tr_wrap;
  logic [IDX_W-1:0] idx_inc;
  assign tr_phase_raw = phase + {{(DIV_W-1){1'b0}}, delta[1:0]};
  assign tr_wrap      = tr_phase_raw >= {1'b0, div_r};
  assign idx_inc      = (IDX == cyc_r - IDX_W'(1)) ? '0 : IDX + IDX_W'(1);

  always_comb begin
    state_nxt   = state;
    t0_nxt      = t0;
    quo_nxt     = quo;
    rem_t_nxt   = rem_t;
    rem_q_nxt   = rem_q;
    cnt_nxt     = cnt;
    div_nxt     = div_r;
    cyc_nxt     = cyc_r;
    i0_nxt      = i0;
    phase_nxt   = phase;
    idx_nxt     = IDX;
    idx_upd_nxt = 1'b0;
    locked_nxt  = LOCKED;

    case (state)
      ST_CAPTURE: begin
        t0_nxt     = SYS_TIME + 64'(RESYNC_LEAD);
        quo_nxt    = SYS_TIME + 64'(RESYNC_LEAD);
        rem_t_nxt  = '0;
        cnt_nxt    = '0;
        locked_nxt = 1'b0;
        state_nxt  = ST_DIV_T;
      end

      ST_DIV_T: begin
        rem_t_nxt = t_ge ? t_sub : t_trial[DIV_W-1:0];
        quo_nxt   = {quo[62:0], t_ge};
        cnt_nxt   = cnt + 6'd1;
        if (cnt == 6'd63) begin
          rem_q_nxt = '0;
          state_nxt = ST_DIV_Q;
        end
      end

      ST_DIV_Q: begin
        rem_q_nxt = rem_q_step;
        quo_nxt   = {quo[62:0], 1'b0};
        cnt_nxt   = cnt + 6'd1;
        if (cnt == 6'd63) begin
          i0_nxt    = rem_q_step;
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (SYS_TIME >= t0) begin
          if (e <= 64'd1) begin
            phase_nxt   = w_wrap ? (w_phase_raw - {1'b0, div_r}) : w_phase_raw;
            idx_nxt     = w_wrap ? i0_inc : i0;
            idx_upd_nxt = 1'b1;
            locked_nxt  = 1'b1;
            state_nxt   = ST_TRACK;
          end else begin
            state_nxt = ST_CAPTURE;
          end
        end
      end

      ST_TRACK: begin
        if (delta == 64'd0) begin
          phase_nxt = phase;
        end else if (delta <= 64'd2) begin
          phase_nxt = tr_wrap ? (tr_phase_raw - {1'b0, div_r}) : tr_phase_raw;
          if (tr_wrap) begin
            idx_nxt     = idx_inc;
            idx_upd_nxt = 1'b1;
          end
        end else begin
          // Time set or jump: IDX holds, LOCKED drops once CAPTURE runs.
          state_nxt = ST_CAPTURE;
        end
      end

      default: state_nxt = ST_CAPTURE;
    endcase

    // A config update overrides whatever the state decided this cycle.
    if (UPDATE) begin
      div_nxt     = (FREQ_DIV < DIV_W'(2)) ? DIV_W'(2) : FREQ_DIV;
      cyc_nxt     = (CYCLE == '0) ? IDX_W'(1) : CYCLE;
      state_nxt   = ST_CAPTURE;
      idx_nxt     = IDX;
      idx_upd_nxt = 1'b0;
      locked_nxt  = LOCKED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_CAPTURE;
      prev_time  <= SYS_TIME;
      t0         <= '0;
      quo        <= '0;
      rem_t      <= '0;
      rem_q      <= '0;
      cnt        <= '0;
      div_r      <= DIV_W'(2);
      cyc_r      <= IDX_W'(1);
      i0         <= '0;
      phase      <= '0;
      IDX        <= '0;
      IDX_UPDATE <= 1'b0;
      LOCKED     <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_time  <= SYS_TIME;
      t0         <= t0_nxt;
      quo        <= quo_nxt;
      rem_t      <= rem_t_nxt;
      rem_q      <= rem_q_nxt;
      cnt        <= cnt_nxt;
      div_r      <= div_nxt;
      cyc_r      <= cyc_nxt;
      i0         <= i0_nxt;
      phase      <= phase_nxt;
      IDX        <= idx_nxt;
      IDX_UPDATE <= idx_upd_nxt;
      LOCKED     <= locked_nxt;
    end
  end

`ifdef SAMPLING_INDEX_GEN_RESYNC_CNT_EN
  // Staying in CAPTURE only happens through UPDATE, which is a fresh entry.
  logic capture_entry;
  assign capture_entry = (state_nxt == ST_CAPTURE) && ((state != ST_CAPTURE) || UPDATE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      RESYNC_CNT <= '0;
    end else if (capture_entry && (RESYNC_CNT != 16'hFFFF)) begin
      RESYNC_CNT <= RESYNC_CNT + 16'd1;
    end
  end
`endif

endmodule
